// File: rtl/sipo_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sipo_ctrl_pkg
//   Shared types and helpers for the serial-in parallel-out frame controller.
//   - state_t   : controller FSM states (IDLE, SHIFT)
//   - cnt_width : width of the bit counter for a given frame width
// ---------------------------------------------------------------------------
package sipo_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter width; a 2-bit frame still needs one counter bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_frame_ctrl_shift.sv
// ---------------------------------------------------------------------------
// sipo_shift_n
//   Enabled right-shift register with synchronous clear. New bits enter at
//   the MSB and older bits move toward the LSB, so after WIDTH shifts the
//   first received bit sits at q[0].
//   Ports:
//     clk  in   clock
//     rst  in   synchronous active-high reset (clears q)
//     clr  in   synchronous clear (priority over en)
//     en   in   shift enable
//     d    in   serial input bit
//     q    out  register contents [WIDTH-1:0]
// ---------------------------------------------------------------------------
module sipo_shift_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= {d, r_q[WIDTH-1:1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sipo_frame_ctrl
//   Frames a strobed serial bit stream into WIDTH-bit words. Bits are
//   accepted in SHIFT when ser_en is high; the WIDTH-th bit completes a word
//   which is captured into a holding register and offered on a valid/ready
//   handshake. A completed word that finds the holding register occupied
//   (and not being drained this cycle) is dropped and sets a sticky overrun.
//   The shift register is independent of the holding register, so the next
//   frame can be received while the previous word waits.
//   Ports:
//     clk          in   clock
//     rst          in   synchronous active-high reset
//     frame_start  in   start / restart a frame
//     ser_in       in   serial data bit
//     ser_en       in   bit strobe
//     out_ready    in   consumer ready
//     clr_ovr      in   clear sticky overrun
//     par_out      out  completed word, first bit at [0]
//     out_valid    out  par_out holds an unconsumed word
//     busy         out  high while in SHIFT
//     bit_cnt      out  bits accepted in current frame
//     overrun      out  sticky dropped-word flag
// ---------------------------------------------------------------------------
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter bit          AUTO_REARM = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        ser_in,
  input  logic                        ser_en,
  input  logic                        out_ready,
  input  logic                        clr_ovr,
  output logic [WIDTH-1:0]            par_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        overrun
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_par;
  logic             r_valid;
  logic             r_ovr;

  logic [WIDTH-1:0] w_sr_q;
  logic [WIDTH-1:0] w_word;
  logic             w_accept;
  logic             w_complete;
  logic             w_xfer;
  logic             w_load;

  // frame_start wins over ser_en, so a strobe in the restart cycle is dropped.
  sipo_shift_n #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk (clk),
    .rst (rst),
    .clr (frame_start),
    .en  (w_accept),
    .d   (ser_in),
    .q   (w_sr_q)
  );

  // The completed word is the value the shift register takes on this edge.
  assign w_word = WIDTH'({ser_in, w_sr_q} >> 1);

  always_comb begin
    w_accept    = (r_state == SHIFT) && ser_en && !frame_start;
    w_complete  = w_accept && (r_cnt == LAST);
    w_xfer      = r_valid && out_ready;
    // Holding register accepts a word if empty or being drained this cycle.
    w_load      = w_complete && (!r_valid || w_xfer);
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          w_state_nxt = SHIFT;
        end else if (w_complete) begin
          w_state_nxt = AUTO_REARM ? SHIFT : IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_complete ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par   <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_par   <= w_word;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  // A drop in the same cycle as clr_ovr leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr <= 1'b0;
    end else if (w_complete && !w_load) begin
      r_ovr <= 1'b1;
    end else if (clr_ovr) begin
      r_ovr <= 1'b0;
    end
  end

  assign par_out   = r_par;
  assign out_valid = r_valid;
  assign busy      = (r_state == SHIFT);
  assign bit_cnt   = r_cnt;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

  localparam int unsigned W = 4;

  bit clk;
  always #5 clk = ~clk;

  // instance 0: AUTO_REARM=0, instance 1: AUTO_REARM=1
  logic       rst0, fs0, se0, sd0, rdy0, clr0;
  logic [3:0] par0;
  logic       val0, busy0, ovr0;
  logic [1:0] cnt0;
  logic       rst1, fs1, se1, sd1, rdy1, clr1;
  logic [3:0] par1;
  logic       val1, busy1, ovr1;
  logic [1:0] cnt1;

  sipo_frame_ctrl #(.WIDTH(W), .AUTO_REARM(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .frame_start(fs0), .ser_in(sd0), .ser_en(se0),
    .out_ready(rdy0), .clr_ovr(clr0), .par_out(par0), .out_valid(val0),
    .busy(busy0), .bit_cnt(cnt0), .overrun(ovr0));

  sipo_frame_ctrl #(.WIDTH(W), .AUTO_REARM(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .frame_start(fs1), .ser_in(sd1), .ser_en(se1),
    .out_ready(rdy1), .clr_ovr(clr1), .par_out(par1), .out_valid(val1),
    .busy(busy1), .bit_cnt(cnt1), .overrun(ovr1));

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: bits are collected by position, word delivered on the
  // WIDTH-th accepted bit, holding register + sticky overrun per the rules.
  int unsigned m_cnt [2];
  logic [3:0]  m_acc [2];
  logic [3:0]  m_par [2];
  bit          m_busy[2];
  bit          m_val [2];
  bit          m_ovr [2];

  task automatic model_step(input int k, input logic rst, fs, en, d, rdy, clr,
                            input bit rearm);
    bit done;
    bit xfer;
    logic [3:0] w;
    done = 0;
    w    = '0;
    xfer = m_val[k] && rdy;
    if (rst) begin
      m_cnt[k] = 0; m_acc[k] = '0; m_par[k] = '0;
      m_busy[k] = 0; m_val[k] = 0; m_ovr[k] = 0;
    end else begin
      if (fs) begin
        m_busy[k] = 1; m_cnt[k] = 0; m_acc[k] = '0;
      end else if (m_busy[k] && en) begin
        m_acc[k][m_cnt[k]] = d;
        m_cnt[k]++;
        if (m_cnt[k] == W) begin
          done = 1;
          w = m_acc[k];
          m_cnt[k] = 0;
          m_acc[k] = '0;
          m_busy[k] = rearm;
        end
      end
      if (clr) m_ovr[k] = 0;
      if (done) begin
        if (!m_val[k] || xfer) begin
          m_par[k] = w;
          m_val[k] = 1;
        end else begin
          m_ovr[k] = 1;
        end
      end else if (xfer) begin
        m_val[k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst0, fs0, se0, sd0, rdy0, clr0, 1'b0);
    model_step(1, rst1, fs1, se1, sd1, rdy1, clr1, 1'b1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("par0",  32'(par0),  32'(m_par[0]));
      chk("val0",  32'(val0),  32'(m_val[0]));
      chk("busy0", 32'(busy0), 32'(m_busy[0]));
      chk("cnt0",  32'(cnt0),  m_cnt[0]);
      chk("ovr0",  32'(ovr0),  32'(m_ovr[0]));
      chk("par1",  32'(par1),  32'(m_par[1]));
      chk("val1",  32'(val1),  32'(m_val[1]));
      chk("busy1", 32'(busy1), 32'(m_busy[1]));
      chk("cnt1",  32'(cnt1),  m_cnt[1]);
      chk("ovr1",  32'(ovr1),  32'(m_ovr[1]));
    end
  end

  task automatic step0(input logic fs, en, d, rdy, clr);
    fs0 = fs; se0 = en; sd0 = d; rdy0 = rdy; clr0 = clr;
    @(negedge clk);
  endtask

  task automatic step1(input logic fs, en, d, rdy, clr);
    fs1 = fs; se1 = en; sd1 = d; rdy1 = rdy; clr1 = clr;
    @(negedge clk);
  endtask

  // bits[0] is sent first
  task automatic send0(input logic [3:0] bits, input logic rdy);
    for (int i = 0; i < 4; i++) step0(1'b0, 1'b1, bits[i], rdy, 1'b0);
  endtask

  task automatic send1(input logic [3:0] bits, input logic rdy);
    for (int i = 0; i < 4; i++) step1(1'b0, 1'b1, bits[i], rdy, 1'b0);
  endtask

  initial begin
    logic [3:0] v;
    rst0 = 1; fs0 = 0; se0 = 0; sd0 = 0; rdy0 = 0; clr0 = 0;
    rst1 = 1; fs1 = 0; se1 = 0; sd1 = 0; rdy1 = 0; clr1 = 0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("lit_rst_par", 32'(par0), 32'h0);
    chk("lit_rst_val", 32'(val0), 32'h0);
    chk("lit_rst_busy", 32'(busy0), 32'h0);
    chk("lit_rst_ovr", 32'(ovr0), 32'h0);
    rst0 = 0; rst1 = 0;
    step0(0, 1, 1, 0, 0);            // ser_en in IDLE ignored

    // frame 1,0,1,1; frame_start with ser_en in IDLE samples nothing
    step0(1, 1, 1, 0, 0);
    chk("lit_fs_busy", 32'(busy0), 32'h1);
    chk("lit_fs_cnt", 32'(cnt0), 32'h0);
    send0(4'b1101, 1'b0);
    chk("lit_f1_par", 32'(par0), 32'hD);
    chk("lit_f1_val", 32'(val0), 32'h1);
    chk("lit_f1_busy", 32'(busy0), 32'h0);

    // second frame dropped; clr_ovr on the dropping cycle loses to the set
    step0(1, 0, 0, 0, 0);
    v = 4'b0110;
    for (int i = 0; i < 3; i++) step0(0, 1, v[i], 0, 0);
    step0(0, 1, v[3], 0, 1);
    chk("lit_ovr_set", 32'(ovr0), 32'h1);
    chk("lit_ovr_par", 32'(par0), 32'hD);
    step0(0, 0, 0, 1, 0);
    chk("lit_drain_val", 32'(val0), 32'h0);
    step0(0, 0, 0, 0, 1);
    chk("lit_ovr_clr", 32'(ovr0), 32'h0);

    // restart mid-frame, including a ser_en=0 hold cycle
    step0(1, 0, 0, 0, 0);
    step0(0, 1, 1, 0, 0);
    step0(0, 0, 0, 0, 0);
    step0(0, 1, 1, 0, 0);
    chk("lit_mid_cnt", 32'(cnt0), 32'h2);
    step0(1, 1, 1, 0, 0);
    chk("lit_restart_cnt", 32'(cnt0), 32'h0);
    send0(4'b0100, 1'b0);
    chk("lit_f3_par", 32'(par0), 32'h4);

    // completion coinciding with a transfer
    step0(1, 0, 0, 0, 0);
    v = 4'b0001;
    for (int i = 0; i < 3; i++) step0(0, 1, v[i], 0, 0);
    step0(0, 1, v[3], 1, 0);
    chk("lit_coin_par", 32'(par0), 32'h1);
    chk("lit_coin_val", 32'(val0), 32'h1);
    chk("lit_coin_ovr", 32'(ovr0), 32'h0);

    // frame_start on the would-be completing cycle
    step0(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step0(0, 1, 1, 0, 0);
    step0(1, 1, 1, 0, 0);
    chk("lit_fswin_cnt", 32'(cnt0), 32'h0);
    chk("lit_fswin_par", 32'(par0), 32'h1);
    step0(0, 0, 0, 1, 0);

    // reset mid-frame, then fresh frame of ones
    step0(1, 0, 0, 0, 0);
    send0(4'b0101, 1'b0);            // leaves a word pending
    step0(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step0(0, 1, 1, 0, 0);
    rst0 = 1;
    step0(0, 1, 1, 0, 0);
    rst0 = 0;
    chk("lit_rst2_par", 32'(par0), 32'h0);
    chk("lit_rst2_val", 32'(val0), 32'h0);
    chk("lit_rst2_cnt", 32'(cnt0), 32'h0);
    chk("lit_rst2_busy", 32'(busy0), 32'h0);
    step0(1, 0, 0, 0, 0);
    send0(4'b1111, 1'b0);
    chk("lit_f6_par", 32'(par0), 32'hF);
    step0(0, 0, 0, 0, 0);

    // auto-rearm: 8 back-to-back strobes, one frame_start
    step1(1, 0, 0, 1, 0);
    send1(4'b1001, 1'b1);
    chk("lit_ar_w1", 32'(par1), 32'h9);
    chk("lit_ar_busy", 32'(busy1), 32'h1);
    send1(4'b1110, 1'b1);
    chk("lit_ar_w2", 32'(par1), 32'hE);
    chk("lit_ar_val", 32'(val1), 32'h1);
    chk("lit_ar_ovr", 32'(ovr1), 32'h0);
    step1(0, 0, 0, 1, 0);
    chk("lit_ar_drain", 32'(val1), 32'h0);
    step1(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
